pwm_multi: RTL and testbench
============================

PWM_MULTI -- requirements
Module: pwm_multi

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent PWM channels (1..8).
REQ-002 Parameter PERIOD, default 10: clocks per PWM period (2..255).
REQ-003 Parameter DUTY_W, default 4: duty register width; SHALL satisfy 2**DUTY_W > PERIOD.
REQ-004 Parameter INIT_DUTY, default 5: duty loaded at reset (0..PERIOD).
REQ-005 Parameter STEP, default 1: duty increment/decrement per accepted press (1..PERIOD).
REQ-006 Parameter DEBOUNCE_W, default 12: debounce tick counter width; one tick every 2**DEBOUNCE_W clocks.
REQ-007 i_clk  input  1  single clock; all state SHALL be on its rising edge.
REQ-008 i_rst  input  1  asynchronous, active-high reset.
REQ-009 i_inc  input  NUM_CH  asynchronous per-channel increase-duty button.
REQ-010 i_dec  input  NUM_CH  asynchronous per-channel decrease-duty button.
REQ-011 i_center  input  1  alignment mode: 0 = left-aligned, 1 = center-aligned; sampled only at period start.
REQ-012 o_pwm  output  NUM_CH  registered PWM outputs.
REQ-013 o_period_start  output  1  one-cycle pulse, registered, high in the cycle o_pwm shows counter value 0.

Function
REQ-014 Each button input SHALL pass a 2-flop synchronizer, then be sampled only on a debounce tick (tick counter all ones); a 0->1 change between consecutive samples SHALL produce a one-clock press pulse.
REQ-015 One free-running tick counter SHALL be shared by all channels; it wraps from all ones to 0.
REQ-016 Inc pulse SHALL set shadow duty to min(shadow+STEP, PERIOD); dec pulse to max(shadow-STEP, 0); arithmetic SHALL be in DUTY_W+1 bits so no wrap occurs.
REQ-017 Simultaneous inc and dec pulses on one channel SHALL leave shadow duty unchanged.
REQ-018 Period counter SHALL count 0..PERIOD-1 and wrap to 0; shadow duty of every channel and i_center SHALL be copied into active registers in the cycle the counter wraps to 0 (no mid-period glitch).
REQ-019 Left-aligned: next o_pwm[c] = (cnt < active_duty[c]).
REQ-020 Center-aligned: offset = (PERIOD - active_duty[c]) >> 1, latched with active duty; next o_pwm[c] = (cnt >= offset) && (cnt < offset + active_duty[c]).
REQ-021 Duty 0 SHALL give constant low; duty PERIOD constant high, in both modes.
REQ-022 o_pwm and o_period_start SHALL lag the counter by exactly one clock.
REQ-023 Press-to-output latency: a new duty SHALL appear on o_pwm no later than the start of the period following the press pulse.

Reset
REQ-024 While i_rst is high: period counter 0, tick counter 0, sync/sample flops 0, shadow and active duty INIT_DUTY, active mode 0, o_pwm all 0, o_period_start 0.
REQ-025 Reset asserted mid-period SHALL take effect immediately, discarding pending presses; first o_period_start SHALL follow one clock after the first post-reset edge.

Structure
REQ-026 Shared package pwm_pkg SHALL hold mode constants (MODE_LEFT=0, MODE_CENTER=1) and the parameter legality checks.
REQ-027 Sub-module pwm_btn_cond SHALL implement synchronizer + tick-sampled edge detect for one button, instantiated 2*NUM_CH times.

Verification
REQ-028 Reset release, defaults, DEBOUNCE_W=4 -> each o_pwm high 5, low 5 clocks; o_period_start every 10 clocks.
REQ-029 Channel 0 inc held 100 clocks (one press) -> ch0 duty 6 from the next period boundary; ch1 stays 5.
REQ-030 Seven inc presses on ch0 -> duty saturates at 10 (o_pwm constant high); seven dec presses -> 3; further 4 dec -> 0 (constant low).
REQ-031 Button bouncing 0/1 every clock for 10 clocks then held high -> exactly one duty step.
REQ-032 i_center=1, duty 4, PERIOD=10 -> o_pwm high for counter 3..6; mode toggle mid-period takes effect next period only.
REQ-033 i_rst pulsed mid-period with duty 8 -> o_pwm 0 during reset, duty restored to 5 after release.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants and parameter legality checks for the multi-channel PWM block.
package pwm_pkg;

  localparam logic MODE_LEFT   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  function automatic bit params_ok(int num_ch, int period, int duty_w, int init_duty,
                                   int step, int debounce_w);
    return (num_ch >= 1) && (num_ch <= 8) &&
           (period >= 2) && (period <= 255) &&
           (duty_w >= 2) && (duty_w <= 16) && ((1 << duty_w) > period) &&
           (init_duty >= 0) && (init_duty <= period) &&
           (step >= 1) && (step <= period) &&
           (debounce_w >= 1) && (debounce_w <= 31);
  endfunction

endpackage

// File: rtl/pwm_btn_cond.sv
// One button: 2-flop synchronizer, sampled on the shared debounce tick, rising-edge press pulse.
module pwm_btn_cond (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic tick,
  output logic press
);

  logic sync1, sync2, sample;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sample <= 1'b0;
      press  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (tick) begin
        sample <= sync2;
        press  <= sync2 & ~sample;
      end
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM with per-channel debounced inc/dec buttons and left/center alignment.
// Shadow duty and mode are transferred to the active set only at the period wrap.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int PERIOD     = 10,
  parameter int DUTY_W     = 4,
  parameter int INIT_DUTY  = 5,
  parameter int STEP       = 1,
  parameter int DEBOUNCE_W = 12
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NUM_CH-1:0] i_inc,
  input  logic [NUM_CH-1:0] i_dec,
  input  logic              i_center,
  output logic [NUM_CH-1:0] o_pwm,
  output logic              o_period_start
);

  if (!params_ok(NUM_CH, PERIOD, DUTY_W, INIT_DUTY, STEP, DEBOUNCE_W)) begin : g_param_check
    $error("pwm_multi: illegal parameter combination");
  end

  localparam logic [DUTY_W:0]   PERIOD_X = (DUTY_W+1)'(PERIOD);
  localparam logic [DUTY_W:0]   STEP_X   = (DUTY_W+1)'(STEP);
  localparam logic [DUTY_W-1:0] LAST_CNT = DUTY_W'(PERIOD - 1);
  localparam logic [DUTY_W-1:0] INIT_D   = DUTY_W'(INIT_DUTY);

  function automatic logic [DUTY_W-1:0] step_duty(logic [DUTY_W-1:0] d, logic inc, logic dec);
    logic [DUTY_W:0] up, dn;
    up = {1'b0, d} + STEP_X;
    dn = {1'b0, d} - STEP_X;
    if (inc && !dec) return (up > PERIOD_X) ? PERIOD_X[DUTY_W-1:0] : up[DUTY_W-1:0];
    if (dec && !inc) return ({1'b0, d} >= STEP_X) ? dn[DUTY_W-1:0] : '0;
    return d;
  endfunction

  function automatic logic [DUTY_W-1:0] center_off(logic [DUTY_W-1:0] d);
    logic [DUTY_W:0] diff;
    diff = PERIOD_X - {1'b0, d};
    return diff[DUTY_W:1];
  endfunction

  logic [DEBOUNCE_W-1:0] tick_cnt;
  logic                  tick;
  logic [NUM_CH-1:0]     inc_press, dec_press;
  logic [DUTY_W-1:0]     cnt;
  logic                  wrap;
  logic [DUTY_W-1:0]     shadow      [NUM_CH];
  logic [DUTY_W-1:0]     shadow_next [NUM_CH];
  logic [DUTY_W-1:0]     active_duty [NUM_CH];
  logic [DUTY_W-1:0]     active_off  [NUM_CH];
  logic                  active_mode;
  logic [NUM_CH-1:0]     pwm_next;

  assign tick = &tick_cnt;
  assign wrap = (cnt == LAST_CNT);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_btn
    pwm_btn_cond u_inc (.clk(i_clk), .rst(i_rst), .btn(i_inc[c]), .tick(tick), .press(inc_press[c]));
    pwm_btn_cond u_dec (.clk(i_clk), .rst(i_rst), .btn(i_dec[c]), .tick(tick), .press(dec_press[c]));
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      shadow_next[c] = step_duty(shadow[c], inc_press[c], dec_press[c]);
    end
  end

  // Compare is against the counter value of this cycle; the register adds the one-clock lag.
  always_comb begin
    pwm_next = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (active_mode == MODE_CENTER)
        pwm_next[c] = (cnt >= active_off[c]) &&
                      ({1'b0, cnt} < ({1'b0, active_off[c]} + {1'b0, active_duty[c]}));
      else
        pwm_next[c] = (cnt < active_duty[c]);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tick_cnt       <= '0;
      cnt            <= '0;
      active_mode    <= MODE_LEFT;
      o_pwm          <= '0;
      o_period_start <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        shadow[c]      <= INIT_D;
        active_duty[c] <= INIT_D;
        active_off[c]  <= center_off(INIT_D);
      end
    end else begin
      tick_cnt       <= tick_cnt + 1'b1;
      cnt            <= wrap ? '0 : cnt + 1'b1;
      o_pwm          <= pwm_next;
      o_period_start <= (cnt == '0);
      for (int c = 0; c < NUM_CH; c++) begin
        shadow[c] <= shadow_next[c];
      end
      // Latch the post-press shadow so a press in the last cycle still lands next period.
      if (wrap) begin
        active_mode <= i_center;
        for (int c = 0; c < NUM_CH; c++) begin
          active_duty[c] <= shadow_next[c];
          active_off[c]  <= center_off(shadow_next[c]);
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: stimulus pushes expected per-period duty/mode, a monitor
// captures whole periods after o_period_start and compares them with the ideal waveform.
module tb_pwm_multi;

  localparam int P = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] inc, dec;
  logic       center;
  logic [1:0] pwm;
  logic       ps;

  always #5 clk = ~clk;

  pwm_multi #(
    .NUM_CH(2), .PERIOD(10), .DUTY_W(4), .INIT_DUTY(5), .STEP(1), .DEBOUNCE_W(4)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_inc(inc), .i_dec(dec), .i_center(center),
    .o_pwm(pwm), .o_period_start(ps)
  );

  typedef struct packed {
    logic       m;
    logic [3:0] d1;
    logic [3:0] d0;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   duty[2];
  logic mode_m;
  bit   mon_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, req);
  endtask

  // Ideal period: d consecutive high clocks, starting at 0 (left) or centred.
  function automatic logic [9:0] pattern(int d, logic m);
    logic [9:0] v;
    int first;
    v = '0;
    first = m ? (P - d) / 2 : 0;
    for (int k = 0; k < P; k++) v[k] = (k >= first) && (k < first + d);
    return v;
  endfunction

  initial begin : monitor
    exp_t       e;
    logic [9:0] cap0, cap1;
    int         ps_err;
    forever begin
      @(negedge clk);
      if (!mon_busy && ps === 1'b1 && rst === 1'b0 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        mon_busy = 1'b1;
        ps_err = 0;
        cap0 = '0;
        cap1 = '0;
        for (int k = 0; k < P; k++) begin
          if (k > 0) @(negedge clk);
          cap0[k] = pwm[0];
          cap1[k] = pwm[1];
          if (ps !== (k == 0)) ps_err++;
        end
        check("period_start_spacing", 32'(ps_err), 32'd0);
        check("ch0_wave", 32'(cap0), 32'(pattern(int'(e.d0), e.m)));
        check("ch1_wave", 32'(cap1), 32'(pattern(int'(e.d1), e.m)));
        mon_busy = 1'b0;
      end
    end
  end

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() > 0 || mon_busy) && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", 32'(t < 400), 32'd1);
  endtask

  function automatic exp_t cur_exp();
    exp_t e;
    e.m  = mode_m;
    e.d1 = 4'(duty[1]);
    e.d0 = 4'(duty[0]);
    return e;
  endfunction

  task automatic expect_periods();
    exp_q.push_back(cur_exp());
    exp_q.push_back(cur_exp());
    wait_drain();
  endtask

  task automatic model_press(input logic [1:0] pi, input logic [1:0] pd);
    for (int c = 0; c < 2; c++) begin
      if (pi[c] && !pd[c]) duty[c] = (duty[c] + 1 > P) ? P : duty[c] + 1;
      else if (pd[c] && !pi[c]) duty[c] = (duty[c] - 1 < 0) ? 0 : duty[c] - 1;
    end
  endtask

  // Hold long enough to straddle a debounce tick, release long enough for a low sample.
  task automatic press(input logic [1:0] pi, input logic [1:0] pd, input int hold);
    inc = pi;
    dec = pd;
    repeat (hold) @(negedge clk);
    inc = '0;
    dec = '0;
    repeat (40) @(negedge clk);
    model_press(pi, pd);
  endtask

  task automatic bounce_inc(input int c);
    for (int i = 0; i < 10; i++) begin
      inc[c] = (i % 2 == 0);
      @(negedge clk);
    end
    inc[c] = 1'b1;
    repeat (40) @(negedge clk);
    inc[c] = 1'b0;
    repeat (40) @(negedge clk);
    model_press(2'(1 << c), 2'b00);
  endtask

  initial begin : watchdog
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stimulus
    int t;
    rst    = 1'b1;
    inc    = '0;
    dec    = '0;
    center = 1'b0;
    mode_m = 1'b0;
    duty   = '{5, 5};
    repeat (3) @(negedge clk);
    check("reset_pwm", 32'(pwm), 32'd0);
    check("reset_period_start", 32'(ps), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("first_period_start", 32'(ps), 32'd1);
    check("first_pwm", 32'(pwm), 32'b11);
    expect_periods();

    press(2'b01, 2'b00, 100);
    expect_periods();

    repeat (7) press(2'b01, 2'b00, 30);
    expect_periods();
    repeat (7) press(2'b00, 2'b01, 30);
    expect_periods();
    repeat (4) press(2'b00, 2'b01, 30);
    expect_periods();

    repeat (40) @(negedge clk);
    bounce_inc(1);
    expect_periods();

    // Center alignment at duty 4, then a mode toggle in the middle of a captured period.
    repeat (2) press(2'b00, 2'b10, 30);
    center = 1'b1;
    mode_m = 1'b1;
    repeat (2 * P) @(negedge clk);
    expect_periods();
    t = 0;
    while (ps !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("ps_seen", 32'(t < 50), 32'd1);
    exp_q.push_back(cur_exp());
    mode_m = ~mode_m;
    exp_q.push_back(cur_exp());
    t = 0;
    while (exp_q.size() > 1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    center = mode_m;
    wait_drain();

    // Reset in the middle of a period with ch0 at duty 8.
    repeat (8) press(2'b01, 2'b00, 30);
    expect_periods();
    repeat ($urandom_range(1, 9)) @(negedge clk);
    rst    = 1'b1;
    center = 1'b0;
    mode_m = 1'b0;
    duty   = '{5, 5};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("in_reset_pwm", 32'(pwm), 32'd0);
      check("in_reset_period_start", 32'(ps), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_period_start", 32'(ps), 32'd1);
    expect_periods();

    for (int it = 0; it < 20; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        center = ~center;
        mode_m = center;
        repeat (2 * P) @(negedge clk);
      end
      press(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom_range(24, 100));
      expect_periods();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
